// File: rtl/uart_rx_buffered.sv
// Buffered 8N1 UART receiver: two-flop RXD synchroniser, mid-bit sampling FSM,
// and a first-word-fall-through FIFO popped through a valid/ready handshake.
module uart_rx_buffered #(
    parameter int BAUD_PERIOD     = 208,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun,
    input  logic       clear_overrun,
    output logic       rx_busy
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W = $clog2(BAUD_PERIOD);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_PERIOD / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_PERIOD - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t                     state;
    logic                       rxd_meta_p0;
    logic                       rxd_s;
    logic [CNT_W-1:0]           baud_cnt;
    logic [2:0]                 bit_cnt;
    logic [7:0]                 shift_reg;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;

    logic bit_tick;
    logic stop_ok;
    logic pop;
    logic full;
    logic push_acc;
    logic drop;

    // Synchroniser stage: idle-high line, so both flops reset to 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_p0 <= 1'b1;
            rxd_s       <= 1'b1;
        end else begin
            rxd_meta_p0 <= RXD;
            rxd_s       <= rxd_meta_p0;
        end
    end

    assign bit_tick = (baud_cnt == BIT_LAST);
    assign stop_ok  = (state == STOP) && bit_tick && rxd_s;
    assign rx_valid = (count != '0);
    assign pop      = rx_valid && rx_ready;
    assign full     = (count == FULL_COUNT);
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands
    assign push_acc = stop_ok && (!full || pop);
    assign drop     = stop_ok && full && !pop;
    assign rx_busy  = (state != IDLE);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

    // Frame FSM stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rxd_s) state <= START;
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= rxd_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= BRK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                BRK: begin
                    // Hold off start detection until the break releases the line
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Deserialiser stage: LSB arrives first, so shift right
    always_ff @(posedge clk) begin
        if (state == DATA && bit_tick) shift_reg <= {rxd_s, shift_reg[7:1]};
    end

    // FIFO stage
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= shift_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)               overrun <= 1'b1;
            else if (clear_overrun) overrun <= 1'b0;
        end
    end

endmodule
